// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if
//   Bundle between the execute side of the pipeline and the memory/write-back
//   stage.
//   master : drives the EX-stage qualifiers, addresses and data, and receives
//            the register-file write port plus the misalignment flag.
//   slave  : the mem_wb_stage side of the same bundle.
//   Signals:
//     ALUResult_EX[31:0]   effective address / ALU writeback value
//     StoreData_EX[31:0]   rs2 value to store
//     PC_EX[31:0]          instruction PC (link value source)
//     WriteReg_EX[4:0]     destination register
//     RegWrite_EX          destination write enable
//     MemtoReg_EX[1:0]     writeback select
//     MemWrite_EX          store enable
//     sw/sh/sb_EX          store width qualifiers
//     lw/lh/lhu/lb/lbu_EX  load width/sign qualifiers
//     RegWrite_MEM         register-file write enable
//     WriteReg_MEM[4:0]    register-file write address
//     WriteData[31:0]      register-file write data
//     MisalignedFault      previous access was misaligned
interface mem_wb_stage_if;
    logic [31:0] ALUResult_EX;
    logic [31:0] StoreData_EX;
    logic [31:0] PC_EX;
    logic [4:0]  WriteReg_EX;
    logic        RegWrite_EX;
    logic [1:0]  MemtoReg_EX;
    logic        MemWrite_EX;
    logic        sw_EX;
    logic        sh_EX;
    logic        sb_EX;
    logic        lw_EX;
    logic        lh_EX;
    logic        lhu_EX;
    logic        lb_EX;
    logic        lbu_EX;

    logic        RegWrite_MEM;
    logic [4:0]  WriteReg_MEM;
    logic [31:0] WriteData;
    logic        MisalignedFault;

    modport master (
        output ALUResult_EX, StoreData_EX, PC_EX, WriteReg_EX, RegWrite_EX,
               MemtoReg_EX, MemWrite_EX, sw_EX, sh_EX, sb_EX,
               lw_EX, lh_EX, lhu_EX, lb_EX, lbu_EX,
        input  RegWrite_MEM, WriteReg_MEM, WriteData, MisalignedFault
    );

    modport slave (
        input  ALUResult_EX, StoreData_EX, PC_EX, WriteReg_EX, RegWrite_EX,
               MemtoReg_EX, MemWrite_EX, sw_EX, sh_EX, sb_EX,
               lw_EX, lh_EX, lhu_EX, lb_EX, lbu_EX,
        output RegWrite_MEM, WriteReg_MEM, WriteData, MisalignedFault
    );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   Memory-access / write-back stage of the 5-stage RV32 pipeline. Performs
//   byte/half/word loads and stores on an internal little-endian data memory
//   and drives the register-file write port back to decode, one cycle after
//   the EX-stage inputs.
//   Parameters:
//     DEPTH_WORDS  data-memory depth in 32-bit words (power of two); higher
//                  address bits are ignored so accesses wrap.
//   Ports:
//     clock  rising-edge clock
//     reset  synchronous, active-high; clears outputs and the whole memory
//     bus    mem_wb_stage_if.slave (EX-stage inputs, write-port outputs)
module mem_wb_stage #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic             clock,
    input  logic             reset,
    mem_wb_stage_if.slave    bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {ST_NONE, ST_W, ST_H, ST_B} store_kind_t;
    typedef enum logic [2:0] {LD_NONE, LD_W, LD_H, LD_HU, LD_B, LD_BU} load_kind_t;

    logic [31:0] mem [DEPTH_WORDS];

    store_kind_t st_kind;
    load_kind_t  ld_kind;
    logic [AW-1:0] word_idx;
    logic [1:0]  byte_off;
    logic        st_misaligned;
    logic        ld_misaligned;
    logic [3:0]  byte_mask;
    logic [31:0] wr_word;
    logic [31:0] rd_word;
    logic [15:0] rd_half;
    logic [7:0]  rd_byte;
    logic [31:0] load_data;
    logic [31:0] wb_data;

    assign word_idx = bus.ALUResult_EX[AW+1:2];
    assign byte_off = bus.ALUResult_EX[1:0];
    assign rd_word  = mem[word_idx];

    always_comb begin
        st_kind = ST_NONE;
        if (bus.MemWrite_EX) begin
            if (bus.sw_EX)      st_kind = ST_W;
            else if (bus.sh_EX) st_kind = ST_H;
            else if (bus.sb_EX) st_kind = ST_B;
        end

        ld_kind = LD_NONE;
        if (bus.lw_EX)       ld_kind = LD_W;
        else if (bus.lh_EX)  ld_kind = LD_H;
        else if (bus.lhu_EX) ld_kind = LD_HU;
        else if (bus.lb_EX)  ld_kind = LD_B;
        else if (bus.lbu_EX) ld_kind = LD_BU;

        st_misaligned = ((st_kind == ST_W) && (byte_off != 2'b00)) ||
                        ((st_kind == ST_H) && byte_off[0]);
        ld_misaligned = ((ld_kind == LD_W) && (byte_off != 2'b00)) ||
                        (((ld_kind == LD_H) || (ld_kind == LD_HU)) && byte_off[0]);

        // Store data is replicated across the word so the byte mask alone
        // picks which lanes land in memory.
        byte_mask = '0;
        wr_word   = '0;
        if (!st_misaligned) begin
            case (st_kind)
                ST_W: begin
                    byte_mask = 4'b1111;
                    wr_word   = bus.StoreData_EX;
                end
                ST_H: begin
                    byte_mask = byte_off[1] ? 4'b1100 : 4'b0011;
                    wr_word   = {2{bus.StoreData_EX[15:0]}};
                end
                ST_B: begin
                    byte_mask = 4'b0001 << byte_off;
                    wr_word   = {4{bus.StoreData_EX[7:0]}};
                end
                default: ;
            endcase
        end

        rd_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
        case (byte_off)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase

        case (ld_kind)
            LD_W:    load_data = rd_word;
            LD_H:    load_data = {{16{rd_half[15]}}, rd_half};
            LD_HU:   load_data = {16'h0000, rd_half};
            LD_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
            LD_BU:   load_data = {24'h000000, rd_byte};
            default: load_data = '0;
        endcase
        if (ld_misaligned) load_data = '0;

        case (bus.MemtoReg_EX)
            2'b01:   wb_data = load_data;
            2'b10:   wb_data = bus.PC_EX + 32'd4;
            default: wb_data = bus.ALUResult_EX;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.RegWrite_MEM    <= 1'b0;
            bus.WriteReg_MEM    <= '0;
            bus.WriteData       <= '0;
            bus.MisalignedFault <= 1'b0;
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            bus.RegWrite_MEM    <= bus.RegWrite_EX && (bus.WriteReg_EX != '0);
            bus.WriteReg_MEM    <= bus.WriteReg_EX;
            bus.WriteData       <= wb_data;
            bus.MisalignedFault <= st_misaligned || ld_misaligned;
            for (int unsigned k = 0; k < 4; k++) begin
                if (byte_mask[k]) begin
                    mem[word_idx][8*k +: 8] <= wr_word[8*k +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
//   Self-checking bench for mem_wb_stage: a directed vector table following
//   the stage's documented behaviour, reset sequences, and a randomized run
//   against a byte-array reference model.
module tb_mem_wb_stage;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned NBYTES = 4 * DEPTH;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    mem_wb_stage_if ifc ();

    mem_wb_stage #(.DEPTH_WORDS(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] pc;
        logic [4:0]  wreg;
        logic        rw;
        logic [1:0]  mt;
        logic        mw;
        logic [2:0]  st;   // {sw, sh, sb}
        logic [4:0]  ld;   // {lw, lh, lhu, lb, lbu}
        logic        e_rw;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic        e_f;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] mdl [NBYTES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ifc.ALUResult_EX = v.addr;
        ifc.StoreData_EX = v.sdata;
        ifc.PC_EX        = v.pc;
        ifc.WriteReg_EX  = v.wreg;
        ifc.RegWrite_EX  = v.rw;
        ifc.MemtoReg_EX  = v.mt;
        ifc.MemWrite_EX  = v.mw;
        {ifc.sw_EX, ifc.sh_EX, ifc.sb_EX} = v.st;
        {ifc.lw_EX, ifc.lh_EX, ifc.lhu_EX, ifc.lb_EX, ifc.lbu_EX} = v.ld;
    endtask

    task automatic check_outs(input string tag, input logic rw, input logic [4:0] wr,
                              input logic [31:0] wd, input logic f);
        check({tag, ".RegWrite_MEM"}, 32'(ifc.RegWrite_MEM), 32'(rw));
        check({tag, ".WriteReg_MEM"}, 32'(ifc.WriteReg_MEM), 32'(wr));
        check({tag, ".WriteData"}, ifc.WriteData, wd);
        check({tag, ".MisalignedFault"}, 32'(ifc.MisalignedFault), 32'(f));
    endtask

    function automatic vec_t mk(logic [31:0] addr, logic [31:0] sdata, logic [31:0] pc,
                                logic [4:0] wreg, logic rw, logic [1:0] mt, logic mw,
                                logic [2:0] st, logic [4:0] ld, logic e_rw,
                                logic [4:0] e_wr, logic [31:0] e_wd, logic e_f);
        vec_t v;
        v = '{addr, sdata, pc, wreg, rw, mt, mw, st, ld, e_rw, e_wr, e_wd, e_f};
        return v;
    endfunction

    // Reference model: plain byte array indexed by the wrapped byte address.
    task automatic model_step(input vec_t v, output logic e_rw, output logic [4:0] e_wr,
                              output logic [31:0] e_wd, output logic e_f);
        int unsigned b;
        logic [31:0] ld_val;
        logic st_fault, ld_fault;
        b = v.addr % NBYTES;
        ld_val = 32'h0;
        ld_fault = 1'b0;
        if (v.ld[4]) begin
            ld_fault = (b % 4) != 0;
            if (!ld_fault) ld_val = {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
        end else if (v.ld[3] || v.ld[2]) begin
            ld_fault = (b % 2) != 0;
            if (!ld_fault) begin
                ld_val = {16'h0, mdl[b+1], mdl[b]};
                if (v.ld[3] && mdl[b+1][7]) ld_val[31:16] = 16'hFFFF;
            end
        end else if (v.ld[1] || v.ld[0]) begin
            ld_val = {24'h0, mdl[b]};
            if (v.ld[1] && mdl[b][7]) ld_val[31:8] = 24'hFFFFFF;
        end
        st_fault = 1'b0;
        if (v.mw && v.st[2]) begin
            st_fault = (b % 4) != 0;
            if (!st_fault) for (int i = 0; i < 4; i++) mdl[b+i] = v.sdata[8*i +: 8];
        end else if (v.mw && v.st[1]) begin
            st_fault = (b % 2) != 0;
            if (!st_fault) for (int i = 0; i < 2; i++) mdl[b+i] = v.sdata[8*i +: 8];
        end else if (v.mw && v.st[0]) begin
            mdl[b] = v.sdata[7:0];
        end
        e_rw = v.rw && (v.wreg != 0);
        e_wr = v.wreg;
        e_f  = st_fault || ld_fault;
        if (v.mt == 2'b01)      e_wd = ld_val;
        else if (v.mt == 2'b10) e_wd = v.pc + 32'd4;
        else                    e_wd = v.addr;
    endtask

    localparam logic [2:0] SW = 3'b100, SH = 3'b010, SB = 3'b001, SN = 3'b000;
    localparam logic [4:0] LW = 5'b10000, LH = 5'b01000, LHU = 5'b00100,
                           LB = 5'b00010, LBU = 5'b00001, LN = 5'b00000;

    initial begin
        vec_t v;
        logic e_rw, e_f;
        logic [4:0] e_wr;
        logic [31:0] e_wd;
        errors = 0;
        checks = 0;

        // Store presented on a reset edge must be discarded.
        reset = 1'b1;
        drive(mk(32'h40, 32'h12345678, 0, 5'd0, 0, 2'b00, 1, SW, LN, 0, 0, 0, 0));
        @(posedge clock); #1;
        @(posedge clock); #1;
        check_outs("reset", 1'b0, 5'd0, 32'h0, 1'b0);
        reset = 1'b0;

        vecs.push_back(mk(32'h10, 0, 0, 5'd1, 1, 2'b01, 0, SN, LW, 1, 5'd1, 32'h0, 0));
        vecs.push_back(mk(32'h40, 0, 0, 5'd2, 1, 2'b01, 0, SN, LW, 1, 5'd2, 32'h0, 0));
        vecs.push_back(mk(32'h20, 32'hDEADBEEF, 0, 5'd0, 0, 2'b00, 1, SW, LN, 0, 5'd0, 32'h20, 0));
        vecs.push_back(mk(32'h20, 0, 0, 5'd5, 1, 2'b01, 0, SN, LW, 1, 5'd5, 32'hDEADBEEF, 0));
        vecs.push_back(mk(32'h21, 32'h0000007F, 0, 5'd0, 0, 2'b00, 1, SB, LN, 0, 5'd0, 32'h21, 0));
        vecs.push_back(mk(32'h20, 0, 0, 5'd6, 1, 2'b01, 0, SN, LW, 1, 5'd6, 32'hDEAD7FEF, 0));
        vecs.push_back(mk(32'h23, 0, 0, 5'd7, 1, 2'b01, 0, SN, LB, 1, 5'd7, 32'hFFFFFFDE, 0));
        vecs.push_back(mk(32'h23, 0, 0, 5'd7, 1, 2'b01, 0, SN, LBU, 1, 5'd7, 32'h000000DE, 0));
        vecs.push_back(mk(32'h22, 0, 0, 5'd8, 1, 2'b01, 0, SN, LH, 1, 5'd8, 32'hFFFFDEAD, 0));
        vecs.push_back(mk(32'h20, 0, 0, 5'd8, 1, 2'b01, 0, SN, LHU, 1, 5'd8, 32'h00007FEF, 0));
        vecs.push_back(mk(32'h22, 32'h11111111, 0, 5'd0, 0, 2'b00, 1, SW, LN, 0, 5'd0, 32'h22, 1));
        vecs.push_back(mk(32'h20, 0, 0, 5'd9, 1, 2'b01, 0, SN, LW, 1, 5'd9, 32'hDEAD7FEF, 0));
        vecs.push_back(mk(32'h21, 0, 0, 5'd9, 1, 2'b01, 0, SN, LH, 1, 5'd9, 32'h0, 1));
        vecs.push_back(mk(32'h55, 0, 32'hFFFFFFFC, 5'd10, 1, 2'b10, 0, SN, LN, 1, 5'd10, 32'h0, 0));
        vecs.push_back(mk(32'h1234, 0, 0, 5'd0, 1, 2'b00, 0, SN, LN, 0, 5'd0, 32'h1234, 0));
        vecs.push_back(mk(32'hABCD, 0, 0, 5'd3, 1, 2'b11, 0, SN, LN, 1, 5'd3, 32'hABCD, 0));
        vecs.push_back(mk(32'h400, 32'hCAFEF00D, 0, 5'd0, 0, 2'b00, 1, SW, LN, 0, 5'd0, 32'h400, 0));
        vecs.push_back(mk(32'h000, 0, 0, 5'd4, 1, 2'b01, 0, SN, LW, 1, 5'd4, 32'hCAFEF00D, 0));
        vecs.push_back(mk(32'h30, 32'h5555, 0, 5'd0, 0, 2'b00, 1, SN, LN, 0, 5'd0, 32'h30, 0));
        vecs.push_back(mk(32'h30, 0, 0, 5'd11, 1, 2'b01, 0, SN, LW, 1, 5'd11, 32'h0, 0));
        vecs.push_back(mk(32'h31, 0, 0, 5'd12, 1, 2'b00, 0, SN, LW, 1, 5'd12, 32'h31, 1));
        vecs.push_back(mk(32'h20, 32'hA5A5A5A5, 0, 5'd0, 0, 2'b00, 0, SW, LN, 0, 5'd0, 32'h20, 0));
        vecs.push_back(mk(32'h20, 0, 0, 5'd13, 1, 2'b01, 0, SN, LW, 1, 5'd13, 32'hDEAD7FEF, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clock); #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_rw, vecs[i].e_wr,
                       vecs[i].e_wd, vecs[i].e_f);
        end

        // Reset must clear memory contents written above.
        reset = 1'b1;
        drive(mk(0, 0, 0, 5'd0, 0, 2'b00, 0, SN, LN, 0, 0, 0, 0));
        @(posedge clock); #1;
        check_outs("reset2", 1'b0, 5'd0, 32'h0, 1'b0);
        reset = 1'b0;
        drive(mk(32'h20, 0, 0, 5'd14, 1, 2'b01, 0, SN, LW, 0, 0, 0, 0));
        @(posedge clock); #1;
        check_outs("post_reset_lw", 1'b1, 5'd14, 32'h0, 1'b0);
        drive(mk(32'h0, 0, 0, 5'd14, 1, 2'b01, 0, SN, LW, 0, 0, 0, 0));
        @(posedge clock); #1;
        check_outs("post_reset_lw0", 1'b1, 5'd14, 32'h0, 1'b0);

        // Randomized run against the byte-array model (memory is all zero now).
        for (int i = 0; i < NBYTES; i++) mdl[i] = 8'h00;
        for (int n = 0; n < 600; n++) begin
            v.addr  = $urandom & ~32'h3C0;   // lower 6 bits live, upper bits exercise wrap
            if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
            v.sdata = $urandom;
            v.pc    = $urandom;
            v.wreg  = 5'($urandom_range(0, 31));
            v.rw    = 1'($urandom_range(0, 1));
            v.mt    = 2'($urandom_range(0, 3));
            v.mw    = 1'($urandom_range(0, 1));
            v.st    = 3'($urandom_range(0, 7));
            v.ld    = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : LN;
            if (v.mt == 2'b01 && v.ld == LN) v.ld = 5'b00001 << $urandom_range(0, 4);
            model_step(v, e_rw, e_wr, e_wd, e_f);
            drive(v);
            @(posedge clock); #1;
            check_outs($sformatf("rand%0d", n), e_rw, e_wr, e_wd, e_f);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
